ysyx_24110006_idu_ctrl: RTL
===========================

// Module: ysyx_24110006_idu_ctrl
// PURPOSE
//  Decode-stage controller between IFU and EXU. Holds one fetched instruction in a stage register and drives the
//  decoder (ysyx_24110006_IDU, instantiated inside) from it. Issues the decoded result to EXU only when no RAW/WAW
//  hazard exists, using a per-register in-flight counter scoreboard. Handles redirect flushes and counts stall cycles.
// PARAMETERS
//  CNT_W   2   width of each scoreboard counter; max in-flight writes per GPR = 2**CNT_W-1
//  NREG    32  number of GPRs tracked (x0 never tracked)
// PORTS
//  clock        in   1   system clock; all state updates on posedge
//  reset        in   1   synchronous, active-high reset
//  i_valid      in   1   IFU offers instruction
//  o_ready      out  1   stage can accept this cycle
//  i_inst       in   32  fetched instruction
//  i_pc         in   32  PC of fetched instruction
//  o_valid      out  1   decoded instruction offered to EXU
//  i_ready      in   1   EXU accepts
//  o_pc         out  32  held PC
//  o_op/o_func  out  7/3 decoder opcode / funct3 of held instruction
//  o_rs1/o_rs2/o_rd out 5 each  decoder register fields
//  o_imm        out  32  decoder immediate
//  i_flush      in   1   redirect: discard held instruction
//  i_wb_valid   in   1   a GPR write retires this cycle
//  i_wb_rd      in   5   destination of retiring write
//  o_stall_cyc  out  32  cycles spent in HOLD with hazard asserted
// BEHAVIOUR
//  - Reset (reset=1 at posedge): state=EMPTY, stage inst=32'h0000_0013 (nop), pc=0, all counters 0, o_stall_cyc=0.
//    Outputs after reset: o_valid=0, o_ready=1. Reset mid-operation drops held instruction, clears scoreboard.
//  - FSM: EMPTY -> HOLD on i_valid&o_ready&~i_flush. HOLD -> EMPTY on fire&~(i_valid) or on i_flush.
//    HOLD -> HOLD on fire&i_valid (back-to-back load, zero bubble) or while not fired.
//  - fire = o_valid & i_ready. o_valid = (state==HOLD) & ~hazard & ~i_flush (comb).
//  - o_ready = ~i_flush & (state==EMPTY | fire). Flush cycle never accepts.
//  - Latency: instruction loaded at edge N is offered at cycle N+1 if hazard-free; decoder fields are comb from stage reg.
//  - Usage decode from opcode: uses_rs1 = op not in {0110111,0010111,1101111}; uses_rs2 = op in {0110011,0100011,
//    1100011}; writes_rd = op not in {0100011,1100011} and rd!=0. Unknown opcodes: uses_rs1 only, no rd write.
//  - hazard = (uses_rs1 & rs1!=0 & cnt[rs1]!=0) | (uses_rs2 & rs2!=0 & cnt[rs2]!=0)
//           | (writes_rd & cnt[rd]==max).  Max-saturation stall prevents counter overflow.
//  - Scoreboard per edge: inc = fire & writes_rd (at rd); dec = i_wb_valid & i_wb_rd!=0 (at i_wb_rd).
//    inc&dec same reg -> unchanged. dec on counter 0 -> ignored (counter stays 0). x0 counter constant 0.
//  - Flush does NOT clear scoreboard (in-flight ops still write back); only held instruction is discarded.
//  - o_stall_cyc increments (wraps 2**32-1 -> 0) each cycle state==HOLD & hazard & ~i_flush.
// CONFIGURATION
//  YSYX_IDU_WB_BYPASS_EN defined: hazard evaluated with counters already reduced by this cycle's dec, i.e. a
//    writeback to rs1/rs2 in cycle N lets the dependent instruction fire in cycle N (regfile write-through assumed).
//  Not defined: hazard uses registered counters only; dependent instruction fires earliest cycle N+1 after wb.
// TESTING
//  1. reset 2 cycles, then addi x1,x0,5 (0x00500093) valid, i_ready=1 -> o_valid next cycle, o_rd=1, o_imm=5, cnt[x1]=1.
//  2. add x2,x1,x1 right after (1) with no wb -> o_valid=0, o_stall_cyc +1/cycle; i_wb_valid,rd=1 at cycle K ->
//     fires cycle K with BYPASS_EN, K+1 without; cnt[x1]=0, cnt[x2]=1.
//  3. stream 4 independent lui (0x000012b7 etc.) with i_ready=1 -> one issue per cycle, o_ready stays 1, no bubbles.
//  4. hold instruction stalled on hazard, assert i_flush with i_valid=1 -> o_valid=0, o_ready=0 that cycle, state
//     EMPTY next, cnt unchanged, new instruction accepted cycle after.
//  5. CNT_W=2: three lw x5 issued w/o wb -> fourth lw x5 stalls (cnt=3); wb x5 -> fourth issues; wb to x0 and
//     wb with cnt=0 -> counters unchanged.
//  6. i_ready=0 for 5 cycles while HOLD hazard-free -> o_valid=1 stable, o_pc/o_imm stable, o_stall_cyc unchanged.

Source files
------------

// File: rtl/ysyx_24110006_idu_ctrl.sv
// Decode-stage controller: one-entry instruction stage, RV32I field decoder, scoreboard hazard check and issue.
// Optional feature macro: YSYX_IDU_WB_BYPASS_EN (same-cycle writeback clears a pending hazard).

module ysyx_24110006_IDU (
    input  logic [31:0] inst,
    output logic [6:0]  op,
    output logic [2:0]  func,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [31:0] imm
);
    // Field extraction and immediate formation per RV32I format
    always_comb begin
        op   = inst[6:0];
        func = inst[14:12];
        rs1  = inst[19:15];
        rs2  = inst[24:20];
        rd   = inst[11:7];
        imm  = 32'h0;
        case (inst[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011:
                imm = {{20{inst[31]}}, inst[31:20]};
            7'b0100011:
                imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            7'b1100011:
                imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                imm = {inst[31:12], 12'h000};
            7'b1101111:
                imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:
                imm = 32'h0;
        endcase
    end
endmodule

module ysyx_24110006_idu_ctrl #(
    parameter int unsigned CNT_W = 2,
    parameter int unsigned NREG  = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_pc,
    output logic [6:0]  o_op,
    output logic [2:0]  o_func,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic [4:0]  o_rd,
    output logic [31:0] o_imm,
    input  logic        i_flush,
    input  logic        i_wb_valid,
    input  logic [4:0]  i_wb_rd,
    output logic [31:0] o_stall_cyc
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [31:0]      NOP     = 32'h0000_0013;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [31:0]       inst_q;
    logic [31:0]       pc_q;
    logic [CNT_W-1:0]  cnt     [NREG];
    logic [CNT_W-1:0]  cnt_eff [NREG];
    logic [NREG-1:0]   dec_hit;
    logic [NREG-1:0]   inc_hit;

    logic known_op;
    logic uses_rs1;
    logic uses_rs2;
    logic writes_rd;
    logic rs1_busy;
    logic rs2_busy;
    logic rd_full;
    logic hazard;
    logic fire;
    logic load;

    ysyx_24110006_IDU u_idu (
        .inst (inst_q),
        .op   (o_op),
        .func (o_func),
        .rs1  (o_rs1),
        .rs2  (o_rs2),
        .rd   (o_rd),
        .imm  (o_imm)
    );

    assign o_pc = pc_q;

    // Register usage classes from opcode; unrecognised opcodes read rs1 only
    always_comb begin
        known_op = 1'b0;
        case (o_op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
            OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM: known_op = 1'b1;
            default: known_op = 1'b0;
        endcase
        uses_rs1  = !((o_op == OP_LUI) || (o_op == OP_AUIPC) || (o_op == OP_JAL));
        uses_rs2  = (o_op == OP_REG) || (o_op == OP_STORE) || (o_op == OP_BRANCH);
        writes_rd = known_op && (o_op != OP_STORE) && (o_op != OP_BRANCH) && (o_rd != 5'd0);
    end

    // Scoreboard lookups; with bypass a retiring write is already visible to this cycle's check
    always_comb begin
        dec_hit  = '0;
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        rd_full  = 1'b0;
        for (int unsigned i = 0; i < NREG; i++) begin
            cnt_eff[i] = cnt[i];
        end
        for (int unsigned i = 1; i < NREG; i++) begin
            dec_hit[i] = i_wb_valid && (i_wb_rd == 5'(i));
`ifdef YSYX_IDU_WB_BYPASS_EN
            if (dec_hit[i] && (cnt[i] != '0)) begin
                cnt_eff[i] = cnt[i] - CNT_ONE;
            end
`endif
            if ((o_rs1 == 5'(i)) && (cnt_eff[i] != '0)) rs1_busy = 1'b1;
            if ((o_rs2 == 5'(i)) && (cnt_eff[i] != '0)) rs2_busy = 1'b1;
            if ((o_rd  == 5'(i)) && (cnt_eff[i] == CNT_MAX)) rd_full = 1'b1;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        hazard    = (uses_rs1 && rs1_busy) || (uses_rs2 && rs2_busy) || (writes_rd && rd_full);
        o_valid   = (state == HOLD) && !hazard && !i_flush;
        fire      = o_valid && i_ready;
        o_ready   = !i_flush && ((state == EMPTY) || fire);
        load      = i_valid && o_ready;
        case (state)
            EMPTY: begin
                if (load) state_nxt = HOLD;
            end
            HOLD: begin
                if (i_flush) begin
                    state_nxt = EMPTY;
                end else if (fire && !i_valid) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        inc_hit = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            inc_hit[i] = fire && writes_rd && (o_rd == 5'(i));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= EMPTY;
            inst_q      <= NOP;
            pc_q        <= 32'h0;
            o_stall_cyc <= 32'h0;
        end else begin
            state <= state_nxt;
            if (load) begin
                inst_q <= i_inst;
                pc_q   <= i_pc;
            end
            if ((state == HOLD) && hazard && !i_flush) begin
                o_stall_cyc <= o_stall_cyc + 32'd1;
            end
        end
    end

    // In-flight write counters; simultaneous issue and retire on one register cancel out
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            cnt[0] <= '0;
            for (int unsigned i = 1; i < NREG; i++) begin
                if (inc_hit[i] && dec_hit[i]) begin
                    cnt[i] <= cnt[i];
                end else if (inc_hit[i]) begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end else if (dec_hit[i] && (cnt[i] != '0)) begin
                    cnt[i] <= cnt[i] - CNT_ONE;
                end
            end
        end
    end
endmodule
